// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-coding definitions.
// Holds default block geometry and coefficient widths, the fixed ZRL/EOB
// symbol codes and the run-length encoder FSM state type.
package jpeg_pkg;

    localparam int unsigned McuSize      = 8;
    localparam int unsigned CoefBitwidth = 12;
    localparam int unsigned IdxBitwidth  = 6;

    localparam int unsigned RunWidth  = 4;
    localparam int unsigned SizeWidth = 4;

    // ZRL: sixteen zeros. EOB: remaining coefficients are all zero.
    localparam logic [RunWidth-1:0]  ZrlRun  = 4'd15;
    localparam logic [SizeWidth-1:0] ZrlSize = 4'd0;
    localparam logic [RunWidth-1:0]  EobRun  = 4'd0;
    localparam logic [SizeWidth-1:0] EobSize = 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StEob
    } rle_state_e;

endpackage

// File: rtl/jpeg_amp_encoder.sv
// Combinational JPEG magnitude-category / amplitude encoder.
//   coef_i : signed quantized coefficient
//   size_o : bit length of |coef_i| (0 for a zero coefficient)
//   amp_o  : coef_i if positive, else (coef_i - 1), truncated to size_o bits,
//            LSB-aligned with upper bits zero
module jpeg_amp_encoder
    import jpeg_pkg::*;
#(
    parameter int unsigned COEF_BITWIDTH = CoefBitwidth
) (
    input  logic [COEF_BITWIDTH-1:0] coef_i,
    output logic [SizeWidth-1:0]     size_o,
    output logic [COEF_BITWIDTH-2:0] amp_o
);

    localparam int unsigned AmpWidth = COEF_BITWIDTH - 1;
    localparam logic [COEF_BITWIDTH-1:0] MostNeg = {1'b1, {AmpWidth{1'b0}}};

    logic [COEF_BITWIDTH-1:0] mag;
    logic [AmpWidth-1:0]      coef_m1;
    logic [AmpWidth-1:0]      raw;
    logic [AmpWidth-1:0]      mask;

    always_comb begin
        mag     = coef_i[COEF_BITWIDTH-1] ? (~coef_i + COEF_BITWIDTH'(1)) : coef_i;
        // Only the low bits of (v - 1) survive truncation, so subtract in that width.
        coef_m1 = coef_i[AmpWidth-1:0] - AmpWidth'(1);

        size_o = '0;
        for (int b = 0; b < int'(COEF_BITWIDTH); b++) begin
            if (mag[b]) begin
                size_o = SizeWidth'(b + 1);
            end
        end

        raw   = coef_i[COEF_BITWIDTH-1] ? coef_m1 : coef_i[AmpWidth-1:0];
        // Shifting out the single set bit at size == AmpWidth wraps to an all-ones mask.
        mask  = (AmpWidth'(1) << size_o) - AmpWidth'(1);
        amp_o = raw & mask;

        // The most negative value has no representable magnitude; pin it.
        if (coef_i == MostNeg) begin
            size_o = SizeWidth'(AmpWidth);
            amp_o  = '0;
        end
    end

endmodule

// File: rtl/ac_run_length_encoder.sv
// JPEG AC run-length encoder.
// Accepts one zigzag-ordered block plus the index of its last nonzero
// coefficient, then emits (run, size, amp) symbols for the AC coefficients,
// including ZRL for runs of sixteen zeros and a closing EOB when the block
// ends before index 63.
//   clk, n_rst          : clock, asynchronous active-low reset
//   i_data, i_last_idx  : block and last-nonzero index, qualified by i_valid
//   i_valid / o_ready   : block handshake (o_ready only while idle)
//   o_run, o_size,
//   o_amp, o_last       : symbol fields, qualified by o_valid
//   o_valid / i_ready   : symbol handshake
module ac_run_length_encoder
    import jpeg_pkg::*;
#(
    parameter int unsigned MCU_SIZE      = McuSize,
    parameter int unsigned COEF_BITWIDTH = CoefBitwidth,
    parameter int unsigned IDX_BITWIDTH  = IdxBitwidth
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic [MCU_SIZE*MCU_SIZE-1:0][COEF_BITWIDTH-1:0] i_data,
    input  logic [IDX_BITWIDTH-1:0]                       i_last_idx,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    output logic [RunWidth-1:0]                           o_run,
    output logic [SizeWidth-1:0]                          o_size,
    output logic [COEF_BITWIDTH-2:0]                      o_amp,
    output logic                                          o_last,
    output logic                                          o_valid,
    input  logic                                          i_ready
);

    localparam int unsigned NumCoef = MCU_SIZE * MCU_SIZE;
    localparam logic [IDX_BITWIDTH-1:0] FinalIdx = IDX_BITWIDTH'(NumCoef - 1);

    rle_state_e state_q, state_d;
    logic [IDX_BITWIDTH-1:0] idx_q, idx_d;
    logic [IDX_BITWIDTH-1:0] last_idx_q, last_idx_d;
    logic [RunWidth-1:0]     run_q, run_d;
    logic                    eob_sent_q, eob_sent_d;
    logic [NumCoef-1:0][COEF_BITWIDTH-1:0] data_q;
    logic                    data_en;

    logic                     valid_q, valid_d;
    logic [RunWidth-1:0]      sym_run_q, sym_run_d;
    logic [SizeWidth-1:0]     sym_size_q, sym_size_d;
    logic [COEF_BITWIDTH-2:0] sym_amp_q, sym_amp_d;
    logic                     sym_last_q, sym_last_d;

    logic [COEF_BITWIDTH-1:0] coef;
    logic [SizeWidth-1:0]     coef_size;
    logic [COEF_BITWIDTH-2:0] coef_amp;
    logic                     advance;

    assign coef = data_q[idx_q];

    jpeg_amp_encoder #(
        .COEF_BITWIDTH(COEF_BITWIDTH)
    ) u_amp (
        .coef_i(coef),
        .size_o(coef_size),
        .amp_o (coef_amp)
    );

    // Output register is free, or its symbol leaves this cycle.
    assign advance = !valid_q || i_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        run_d      = run_q;
        eob_sent_d = eob_sent_q;
        data_en    = 1'b0;
        valid_d    = valid_q && !i_ready;
        sym_run_d  = sym_run_q;
        sym_size_d = sym_size_q;
        sym_amp_d  = sym_amp_q;
        sym_last_d = sym_last_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    data_en    = 1'b1;
                    last_idx_d = i_last_idx;
                    idx_d      = IDX_BITWIDTH'(1);
                    run_d      = '0;
                    eob_sent_d = 1'b0;
                    state_d    = (i_last_idx == '0) ? StEob : StScan;
                end
            end
            StScan: begin
                if (advance) begin
                    if (coef == '0) begin
                        if (run_q == ZrlRun) begin
                            valid_d    = 1'b1;
                            sym_run_d  = ZrlRun;
                            sym_size_d = ZrlSize;
                            sym_amp_d  = '0;
                            sym_last_d = 1'b0;
                            run_d      = '0;
                        end else begin
                            run_d = run_q + RunWidth'(1);
                        end
                    end else begin
                        valid_d    = 1'b1;
                        sym_run_d  = run_q;
                        sym_size_d = coef_size;
                        sym_amp_d  = coef_amp;
                        sym_last_d = (idx_q == FinalIdx);
                        run_d      = '0;
                    end

                    if (idx_q == FinalIdx) begin
                        state_d = StIdle;
                    end else if (idx_q == last_idx_q) begin
                        state_d = StEob;
                    end else begin
                        idx_d = idx_q + IDX_BITWIDTH'(1);
                    end
                end
            end
            StEob: begin
                if (eob_sent_q) begin
                    if (i_ready) begin
                        state_d = StIdle;
                    end
                end else if (advance) begin
                    valid_d    = 1'b1;
                    sym_run_d  = EobRun;
                    sym_size_d = EobSize;
                    sym_amp_d  = '0;
                    sym_last_d = 1'b1;
                    eob_sent_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_idx_q <= '0;
            run_q      <= '0;
            eob_sent_q <= 1'b0;
            valid_q    <= 1'b0;
            sym_run_q  <= '0;
            sym_size_q <= '0;
            sym_amp_q  <= '0;
            sym_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            run_q      <= run_d;
            eob_sent_q <= eob_sent_d;
            valid_q    <= valid_d;
            sym_run_q  <= sym_run_d;
            sym_size_q <= sym_size_d;
            sym_amp_q  <= sym_amp_d;
            sym_last_q <= sym_last_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
        end else if (data_en) begin
            data_q <= i_data;
        end
    end

    // Gate with n_rst so the encoder never advertises readiness while held in reset.
    assign o_ready = (state_q == StIdle) && n_rst;
    assign o_valid = valid_q;
    assign o_run   = sym_run_q;
    assign o_size  = sym_size_q;
    assign o_amp   = sym_amp_q;
    assign o_last  = sym_last_q;

endmodule
